// File: rtl/mux_addr.sv
// Register-file write-address selector: picks rt, rd or link as the destination register,
// with a registered copy and status flags. Optional build macro: MUX_ADDR_LINK_FORCE_EN.
module mux_addr #(
    parameter int                 ADDR_W     = 5,
    parameter logic [ADDR_W-1:0]  RESET_ADDR = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [ADDR_W-1:0] addr3,
    input  logic [1:0]        RegDst,
    output logic [ADDR_W-1:0] addr_w,
    output logic [ADDR_W-1:0] addr_w_q,
    output logic              addr_zero,
    output logic              sel_err,
    output logic              sel_err_sticky
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ONES_ADDR = {ADDR_W{1'b1}};

    logic [ADDR_W-1:0] addr_sel_s;
    logic              sel_err_s;
    logic [ADDR_W-1:0] addr_q_r;
    logic              sticky_r;

    // Destination select; the illegal code 2'b11 either forces the link register or yields $0.
    always_comb begin
        addr_sel_s = ZERO_ADDR;
        case (RegDst)
            2'b00:   addr_sel_s = addr1;
            2'b01:   addr_sel_s = addr2;
            2'b10:   addr_sel_s = addr3;
            default: begin
`ifdef MUX_ADDR_LINK_FORCE_EN
                addr_sel_s = ONES_ADDR;
`else
                addr_sel_s = ZERO_ADDR;
`endif
            end
        endcase
    end

`ifdef MUX_ADDR_LINK_FORCE_EN
    assign sel_err_s = 1'b0;
`else
    assign sel_err_s = (RegDst == 2'b11);
`endif

    // Write-back copy and sticky illegal-select flag, captured only when enabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q_r <= RESET_ADDR;
            sticky_r <= 1'b0;
        end else if (en) begin
            addr_q_r <= addr_sel_s;
            sticky_r <= sticky_r | sel_err_s;
        end
    end

    assign addr_w         = addr_sel_s;
    assign addr_zero      = (addr_sel_s == ZERO_ADDR);
    assign sel_err        = sel_err_s;
    assign addr_w_q       = addr_q_r;
    assign sel_err_sticky = sticky_r;

endmodule

// File: tb/tb_mux_addr.sv
// Self-checking bench for mux_addr: queued expectations for the combinational and registered paths.
module tb_mux_addr;

    localparam int ADDR_W = 5;

    logic              clk;
    logic              reset;
    logic              en;
    logic [ADDR_W-1:0] addr1, addr2, addr3;
    logic [1:0]        RegDst;
    logic [ADDR_W-1:0] addr_w, addr_w_q;
    logic              addr_zero, sel_err, sel_err_sticky;

    typedef struct {
        logic [ADDR_W-1:0] aw;
        logic              z;
        logic              e;
    } comb_t;

    typedef struct {
        logic [ADDR_W-1:0] q;
        logic              s;
    } reg_t;

    comb_t comb_q[$];
    reg_t  reg_q[$];

    int total;
    int bad;

    logic [ADDR_W-1:0] mdl_q;
    logic              mdl_s;

    mux_addr #(.ADDR_W(ADDR_W), .RESET_ADDR(5'd0)) dut (
        .clk(clk), .reset(reset), .en(en),
        .addr1(addr1), .addr2(addr2), .addr3(addr3), .RegDst(RegDst),
        .addr_w(addr_w), .addr_w_q(addr_w_q), .addr_zero(addr_zero),
        .sel_err(sel_err), .sel_err_sticky(sel_err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got running, need finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, need %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [ADDR_W-1:0] ref_addr(input logic [1:0] rd, input logic [ADDR_W-1:0] a1,
                                                   input logic [ADDR_W-1:0] a2, input logic [ADDR_W-1:0] a3);
        if (rd == 2'b00) return a1;
        if (rd == 2'b01) return a2;
        if (rd == 2'b10) return a3;
`ifdef MUX_ADDR_LINK_FORCE_EN
        return 5'd31;
`else
        return 5'd0;
`endif
    endfunction

    function automatic logic ref_err(input logic [1:0] rd);
`ifdef MUX_ADDR_LINK_FORCE_EN
        return 1'b0;
`else
        return (rd == 2'b11);
`endif
    endfunction

    task automatic pop_comb(input string tag);
        comb_t c;
        if (comb_q.size() == 0) begin
            check({tag, "_comb_queue_empty"}, 32'd0, 32'd1);
        end else begin
            c = comb_q.pop_front();
            check({tag, "_addr_w"}, 32'(addr_w), 32'(c.aw));
            check({tag, "_addr_zero"}, 32'(addr_zero), 32'(c.z));
            check({tag, "_sel_err"}, 32'(sel_err), 32'(c.e));
        end
    endtask

    task automatic pop_reg(input string tag);
        reg_t r;
        if (reg_q.size() == 0) begin
            check({tag, "_reg_queue_empty"}, 32'd0, 32'd1);
        end else begin
            r = reg_q.pop_front();
            check({tag, "_addr_w_q"}, 32'(addr_w_q), 32'(r.q));
            check({tag, "_sticky"}, 32'(sel_err_sticky), 32'(r.s));
        end
    endtask

    // Drive inputs after a falling edge and check the zero-latency path with no clock edge.
    task automatic apply(input string tag, input logic e, input logic [1:0] rd,
                         input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2, input logic [ADDR_W-1:0] a3);
        comb_t c;
        @(negedge clk);
        en = e; RegDst = rd; addr1 = a1; addr2 = a2; addr3 = a3;
        c.aw = ref_addr(rd, a1, a2, a3);
        c.z  = (c.aw == 5'd0);
        c.e  = ref_err(rd);
        comb_q.push_back(c);
        #1;
        pop_comb(tag);
    endtask

    // One rising edge; the model captures the pre-edge selection when enabled and not in reset.
    task automatic tick(input string tag);
        reg_t r;
        if (!reset && en) begin
            mdl_q = ref_addr(RegDst, addr1, addr2, addr3);
            mdl_s = mdl_s | ref_err(RegDst);
        end
        r.q = mdl_q; r.s = mdl_s;
        reg_q.push_back(r);
        @(posedge clk);
        #1;
        pop_reg(tag);
    endtask

    // Asynchronous reset pulse away from any clock edge.
    task automatic pulse_reset(input string tag);
        reg_t r;
        @(negedge clk);
        #2;
        reset = 1'b1;
        mdl_q = 5'd0; mdl_s = 1'b0;
        r.q = mdl_q; r.s = mdl_s;
        reg_q.push_back(r);
        #1;
        pop_reg(tag);
        reset = 1'b0;
    endtask

    initial begin
        total = 0; bad = 0;
        reset = 1'b1; en = 1'b0; RegDst = 2'b00;
        addr1 = 5'd0; addr2 = 5'd0; addr3 = 5'd0;
        mdl_q = 5'd0; mdl_s = 1'b0;
        reg_q.push_back('{q: 5'd0, s: 1'b0});
        #1;
        pop_reg("reset_state");

        apply("en_during_reset", 1'b1, 2'b01, 5'd0, 5'd9, 5'd0);
        tick("held_in_reset");
        reset = 1'b0;

        apply("sweep_rt",   1'b0, 2'b00, 5'd8, 5'd16, 5'd31);
        apply("sweep_rd",   1'b0, 2'b01, 5'd8, 5'd16, 5'd31);
        apply("sweep_link", 1'b0, 2'b10, 5'd8, 5'd16, 5'd31);
        tick("en_low_hold");

        apply("cap_set", 1'b1, 2'b01, 5'd8, 5'd12, 5'd31);
        tick("cap_12");
        apply("hold_set", 1'b0, 2'b01, 5'd8, 5'd3, 5'd31);
        tick("hold_1");
        tick("hold_2");

        apply("illegal", 1'b1, 2'b11, 5'd8, 5'd3, 5'd4);
        tick("illegal_cap");
        apply("back_rt", 1'b0, 2'b00, 5'd8, 5'd3, 5'd4);
        tick("sticky_hold");
        apply("back_rt_en", 1'b1, 2'b00, 5'd8, 5'd3, 5'd4);
        tick("sticky_keep");
        apply("recap_12", 1'b1, 2'b01, 5'd8, 5'd12, 5'd4);
        tick("recap_12");

        pulse_reset("async_reset");
        apply("post_reset", 1'b1, 2'b10, 5'd8, 5'd12, 5'd31);
        tick("first_edge_after_reset");

        apply("zero_rt", 1'b0, 2'b00, 5'd0, 5'd12, 5'd31);
        apply("one_rt",  1'b0, 2'b00, 5'd1, 5'd12, 5'd31);
        apply("zero_rd", 1'b0, 2'b01, 5'd1, 5'd0, 5'd31);
        apply("ones_rt", 1'b0, 2'b00, 5'd31, 5'd0, 5'd31);

        for (int i = 0; i < 40; i++) begin
            apply("rand", 1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)),
                  5'($urandom), 5'($urandom), 5'($urandom));
            tick("rand_tick");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
